// File: rtl/trapezoid_filter_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : trapezoid_filter_cfg
//  Purpose  : Runtime-configurable pipelined trapezoidal shaper for one ADC
//             channel, with circular delay line and saturating output.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef SIZE_ADC_DATA
`define SIZE_ADC_DATA 12
`endif
`ifndef SIZE_FILTER_DATA
`define SIZE_FILTER_DATA 16
`endif

module trapezoid_filter_cfg #(
    parameter int DATA_W    = `SIZE_ADC_DATA,
    parameter int OUT_W     = `SIZE_FILTER_DATA,
    parameter int ACC_W     = 40,
    parameter int MAX_DEPTH = 64,
    parameter int M_W       = 8,
    parameter int DEF_K     = 8,
    parameter int DEF_L     = 16,
    parameter int DEF_M     = 0,
    parameter int DEF_SHIFT = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(MAX_DEPTH):0]   cfg_k,
    input  logic [$clog2(MAX_DEPTH):0]   cfg_l,
    input  logic [M_W-1:0]               cfg_m,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_load,
    output logic                         cfg_err,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            input_data,
    output logic                         out_valid,
    output logic signed [OUT_W-1:0]      output_data,
    output logic                         overflow
);

    localparam int AW  = $clog2(MAX_DEPTH);
    localparam int KW  = AW + 1;
    localparam int DW2 = DATA_W + 2;
    localparam int PW  = M_W + 1 + DW2;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [AW-1:0]            r_cfg_k;
    logic [AW-1:0]            r_cfg_l;
    logic [M_W-1:0]           r_cfg_m;
    logic [4:0]               r_cfg_shift;
    logic                     r_cfg_err;

    logic [AW-1:0]            r_clr_cnt;
    logic [AW-1:0]            r_wp;
    logic                     w_clr_last;
    logic                     w_in_ready;

    logic [KW:0]              w_kl_sum;
    logic                     w_cfg_valid;
    logic                     w_cfg_ok;
    logic                     w_accept;

    logic [DATA_W-1:0]        r_mem [MAX_DEPTH];
    logic                     w_mem_we;
    logic [AW-1:0]            w_mem_wa;
    logic [DATA_W-1:0]        w_mem_wd;
    logic [AW-1:0]            w_ak;
    logic [AW-1:0]            w_al;
    logic [AW-1:0]            w_akl;

    logic signed [DW2-1:0]    w_x0;
    logic signed [DW2-1:0]    w_xk;
    logic signed [DW2-1:0]    w_xl;
    logic signed [DW2-1:0]    w_xkl;
    logic signed [DW2-1:0]    w_d;

    logic signed [DW2-1:0]    r_d;
    logic signed [ACC_W-1:0]  r_p;
    logic signed [ACC_W-1:0]  r_mterm;
    logic signed [ACC_W-1:0]  r_r;
    logic signed [ACC_W-1:0]  r_s;
    logic                     r_v1;
    logic                     r_v2;
    logic                     r_v3;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out_data;
    logic                     r_ovf;

    logic signed [ACC_W-1:0]  w_d_ext;
    logic signed [PW-1:0]     w_m_a;
    logic signed [PW-1:0]     w_m_b;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_m_ext;
    logic signed [ACC_W-1:0]  w_s_next;
    logic signed [ACC_W-1:0]  w_sh;
    logic [ACC_W-OUT_W:0]     w_hi;
    logic                     w_clip;
    logic signed [OUT_W-1:0]  w_sat;

    // ------------------------------------------------------------------
    // Configuration validation and latching
    // ------------------------------------------------------------------
    assign w_kl_sum    = {1'b0, cfg_k} + {1'b0, cfg_l};
    assign w_cfg_valid = (cfg_k != '0) && (cfg_k <= cfg_l)
                         && (w_kl_sum <= (KW+1)'(MAX_DEPTH));
    assign w_cfg_ok    = cfg_load && w_cfg_valid;

    // A valid reconfiguration takes priority over a same-cycle sample.
    assign w_accept    = in_valid && w_in_ready && !w_cfg_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg_k     <= AW'(DEF_K);
            r_cfg_l     <= AW'(DEF_L);
            r_cfg_m     <= M_W'(DEF_M);
            r_cfg_shift <= 5'(DEF_SHIFT);
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= cfg_load && !w_cfg_valid;
            if (w_cfg_ok) begin
                r_cfg_k     <= cfg_k[AW-1:0];
                r_cfg_l     <= cfg_l[AW-1:0];
                r_cfg_m     <= cfg_m;
                r_cfg_shift <= cfg_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: CLEAR sweeps the delay line, RUN processes samples
    // ------------------------------------------------------------------
    assign w_clr_last = (r_clr_cnt == AW'(MAX_DEPTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_CLEAR: begin
                if (w_clr_last) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_in_ready = 1'b1;
            end
            default: begin
                w_state_next = S_CLEAR;
            end
        endcase
        if (w_cfg_ok) begin
            w_state_next = S_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt <= '0;
            r_wp      <= '0;
        end else if (w_cfg_ok) begin
            r_clr_cnt <= '0;
            r_wp      <= '0;
        end else begin
            if (r_state == S_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + AW'(1);
            end
            if (w_accept) begin
                r_wp <= r_wp + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Circular delay line; taps are read before the new sample lands
    // ------------------------------------------------------------------
    assign w_mem_we = (r_state == S_CLEAR) || w_accept;
    assign w_mem_wa = (r_state == S_CLEAR) ? r_clr_cnt : r_wp;
    assign w_mem_wd = (r_state == S_CLEAR) ? '0 : input_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    // When k+l equals the depth, w_akl aliases r_wp and yields the oldest sample.
    assign w_ak  = r_wp - r_cfg_k;
    assign w_al  = r_wp - r_cfg_l;
    assign w_akl = r_wp - r_cfg_k - r_cfg_l;

    assign w_x0  = $signed({2'b00, input_data});
    assign w_xk  = $signed({2'b00, r_mem[w_ak]});
    assign w_xl  = $signed({2'b00, r_mem[w_al]});
    assign w_xkl = $signed({2'b00, r_mem[w_akl]});
    assign w_d   = w_x0 - w_xk - w_xl + w_xkl;

    // ------------------------------------------------------------------
    // Arithmetic datapath helpers
    // ------------------------------------------------------------------
    assign w_d_ext  = {{(ACC_W-DW2){r_d[DW2-1]}}, r_d};
    assign w_m_a    = {{(PW-M_W){1'b0}}, r_cfg_m};
    assign w_m_b    = {{(PW-DW2){r_d[DW2-1]}}, r_d};
    assign w_prod   = w_m_a * w_m_b;
    assign w_m_ext  = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

    assign w_s_next = r_s + r_r;
    assign w_sh     = w_s_next >>> r_cfg_shift;
    // In range only when every bit above the output sign bit matches it.
    assign w_hi     = w_sh[ACC_W-1:OUT_W-1];
    assign w_clip   = !((&w_hi) || (~|w_hi));
    assign w_sat    = !w_clip ? w_sh[OUT_W-1:0]
                    : (w_sh[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}});

    // ------------------------------------------------------------------
    // Four-stage pipeline: d -> p,m -> r -> s,output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d         <= '0;
            r_p         <= '0;
            r_mterm     <= '0;
            r_r         <= '0;
            r_s         <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
        end else if (w_cfg_ok) begin
            r_d         <= '0;
            r_p         <= '0;
            r_mterm     <= '0;
            r_r         <= '0;
            r_s         <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_v1        <= w_accept;
            r_v2        <= r_v1;
            r_v3        <= r_v2;
            r_out_valid <= r_v3;
            r_ovf       <= r_v3 && w_clip;
            if (w_accept) begin
                r_d <= w_d;
            end
            if (r_v1) begin
                r_p     <= r_p + w_d_ext;
                r_mterm <= w_m_ext;
            end
            if (r_v2) begin
                r_r <= r_p + r_mterm;
            end
            if (r_v3) begin
                r_s        <= w_s_next;
                r_out_data <= w_sat;
            end
        end
    end

    assign cfg_err     = r_cfg_err;
    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign output_data = r_out_data;
    assign overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_trapezoid_filter_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trapezoid_filter_cfg
//  Purpose  : Directed, table-driven self-checking bench for trapezoid_filter_cfg.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_trapezoid_filter_cfg;

    localparam int DATA_W    = 12;
    localparam int OUT_W     = 16;
    localparam int ACC_W     = 40;
    localparam int MAX_DEPTH = 64;
    localparam int M_W       = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [6:0]              cfg_k = '0;
    logic [6:0]              cfg_l = '0;
    logic [M_W-1:0]          cfg_m = '0;
    logic [4:0]              cfg_shift = '0;
    logic                    cfg_load = 1'b0;
    logic                    cfg_err;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [DATA_W-1:0]       input_data = '0;
    logic                    out_valid;
    logic signed [OUT_W-1:0] output_data;
    logic                    overflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic [11:0] x;
        logic        ld;
        logic [6:0]  k;
        logic [6:0]  l;
        logic [7:0]  m;
        logic [4:0]  sh;
        logic        e_ov;
        int          e_d;
        logic        e_of;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    trapezoid_filter_cfg #(
        .DATA_W    (DATA_W),
        .OUT_W     (OUT_W),
        .ACC_W     (ACC_W),
        .MAX_DEPTH (MAX_DEPTH),
        .M_W       (M_W),
        .DEF_K     (8),
        .DEF_L     (16),
        .DEF_M     (0),
        .DEF_SHIFT (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_k       (cfg_k),
        .cfg_l       (cfg_l),
        .cfg_m       (cfg_m),
        .cfg_shift   (cfg_shift),
        .cfg_load    (cfg_load),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .input_data  (input_data),
        .out_valid   (out_valid),
        .output_data (output_data),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Counts cycles until in_ready rises; outputs must stay quiet meanwhile.
    task automatic wait_ready(input string nm);
        int n   = 0;
        int bad = 0;
        while (!in_ready && n < 200) begin
            if (out_valid || output_data != 0 || overflow) bad++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_clear_len"}, n, 64);
        chk({nm, "_clear_quiet"}, bad, 0);
    endtask

    task automatic configure(input string nm, input int k, input int l, input int m,
                             input int sh, input logic v, input int x);
        cfg_k      = 7'(k);
        cfg_l      = 7'(l);
        cfg_m      = 8'(m);
        cfg_shift  = 5'(sh);
        cfg_load   = 1'b1;
        in_valid   = v;
        input_data = 12'(x);
        @(posedge clk); #1;
        cfg_load   = 1'b0;
        in_valid   = 1'b0;
        chk({nm, "_cfg_err"}, int'(cfg_err), 0);
        wait_ready(nm);
    endtask

    // Sample j is driven on row j*step; its result is observed on row j*step+3.
    task automatic build(input int xs[8], input int ys[8], input int ofs[8], input int step);
        int   nrow;
        int   held;
        vec_t e;
        nrow = 7 * step + 5;
        held = 0;
        tbl.delete();
        for (int r = 0; r < nrow; r++) begin
            e = '{v: 1'b0, x: 12'd0, ld: 1'b0, k: 7'd0, l: 7'd0, m: 8'd0, sh: 5'd0,
                  e_ov: 1'b0, e_d: 0, e_of: 1'b0, e_err: 1'b0};
            if ((r % step) == 0 && (r / step) < 8) begin
                e.v = 1'b1;
                e.x = 12'(xs[r / step]);
            end
            if (r >= 3 && ((r - 3) % step) == 0 && ((r - 3) / step) < 8) begin
                e.e_ov = 1'b1;
                held   = ys[(r - 3) / step];
                e.e_of = ofs[(r - 3) / step] != 0;
            end
            e.e_d = held;
            tbl.push_back(e);
        end
    endtask

    task automatic run_tbl(input string nm);
        foreach (tbl[i]) begin
            in_valid   = tbl[i].v;
            input_data = tbl[i].x;
            cfg_load   = tbl[i].ld;
            cfg_k      = tbl[i].k;
            cfg_l      = tbl[i].l;
            cfg_m      = tbl[i].m;
            cfg_shift  = tbl[i].sh;
            @(posedge clk); #1;
            chk($sformatf("%s[%0d].out_valid", nm, i), int'(out_valid), int'(tbl[i].e_ov));
            chk($sformatf("%s[%0d].output_data", nm, i), int'(output_data), tbl[i].e_d);
            chk($sformatf("%s[%0d].overflow", nm, i), int'(overflow), int'(tbl[i].e_of));
            chk($sformatf("%s[%0d].cfg_err", nm, i), int'(cfg_err), int'(tbl[i].e_err));
            chk($sformatf("%s[%0d].in_ready", nm, i), int'(in_ready), 1);
        end
        in_valid = 1'b0;
        cfg_load = 1'b0;
    endtask

    int imp_x[8]   = '{0, 10, 0, 0, 0, 0, 0, 0};
    int imp_y[8]   = '{0, 10, 20, 20, 20, 10, 0, 0};
    int imp3_y[8]  = '{0, 20, 25, 10, 10, -10, -15, 0};
    int stp_x[8]   = '{0, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    int sat_y[8]   = '{0, 32767, 32767, 32767, 32767, 32767, 32760, 32760};
    int sat_of[8]  = '{0, 1, 1, 1, 1, 1, 0, 0};
    int no_of[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int bad;

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_output_data", int'(output_data), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        reset = 1'b1;
        wait_ready("por");

        // Impulse of 10 with k=2, l=4, M=0: trapezoid 10,20,20,20,10,0
        configure("cfg_a", 2, 4, 0, 0, 1'b0, 0);
        build(imp_x, imp_y, no_of, 1);
        run_tbl("impulse");

        // Same stimulus with every other cycle idle, plus rejected configurations
        configure("cfg_b", 2, 4, 0, 0, 1'b0, 0);
        build(imp_x, imp_y, no_of, 2);
        tbl[1].ld = 1'b1; tbl[1].k = 7'd0;  tbl[1].l = 7'd4;  tbl[1].e_err = 1'b1;
        tbl[3].ld = 1'b1; tbl[3].k = 7'd5;  tbl[3].l = 7'd3;  tbl[3].e_err = 1'b1;
        tbl[5].ld = 1'b1; tbl[5].k = 7'd40; tbl[5].l = 7'd40; tbl[5].e_err = 1'b1;
        run_tbl("gapped");

        // Pole-zero term and arithmetic shift with negative results
        configure("cfg_c", 2, 4, 3, 1, 1'b0, 0);
        build(imp_x, imp3_y, no_of, 1);
        run_tbl("mshift");

        // Full-scale step with M=255 saturates, then settles back in range
        configure("cfg_d", 2, 4, 255, 0, 1'b0, 0);
        build(stp_x, sat_y, sat_of, 1);
        run_tbl("saturate");

        // Asynchronous reset in the middle of a cycle clears immediately
        #2 reset = 1'b0;
        #1;
        chk("async_rst_in_ready", int'(in_ready), 0);
        chk("async_rst_output_data", int'(output_data), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        wait_ready("rerst");

        // Reconfiguration mid-stream with a same-cycle sample
        configure("cfg_e", 2, 4, 0, 0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            input_data = (i == 0) ? 12'd0 : 12'd10;
            @(posedge clk); #1;
        end
        chk("midstream_busy", int'(out_valid), 1);
        configure("cfg_f", 2, 4, 0, 0, 1'b1, 10);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) bad++;
            @(posedge clk); #1;
        end
        chk("midstream_dropped", bad, 0);
        build(imp_x, imp_y, no_of, 1);
        run_tbl("post_reconfig");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
